// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS32 subset core (add/sub/and/or/slt, addi, lw, sw,
// beq, j). One shared ALU and one unified memory port with a req/ready handshake, so any
// memory latency is tolerated.
// Optional feature: define MIPS_MC_ILLEGAL_TRAP_EN to halt on an unsupported instruction;
// when it is undefined such instructions retire as NOPs.
module mips_multicycle_core #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter bit          HALT_ON_J = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              retire,
    output logic [ADDR_W-1:0] dbg_pc
);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]       aluout_q, aluout_d, mdr_q, mdr_d;
    logic [31:0]       regs_q [32];

    logic [5:0]         opcode, funct;
    logic signed [31:0] imm_sext, alu_a, alu_b;
    logic [31:0]        alu_res;
    logic               is_rtype, is_addi, is_lw, is_sw, is_beq, is_j;
    logic               rfn_ok, illegal, j_halt;
    logic [ADDR_W-1:0]  j_target;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [31:0]        rf_wdata;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign rfn_ok   = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    assign illegal  = !((is_rtype && rfn_ok) || is_addi || is_lw || is_sw || is_beq || is_j);

    // Jump target keeps the top four bits of pc+4 (zero when ADDR_W <= 28), then wraps.
    // pc_q already holds pc+4 during EXEC, so the j's own address is pc_q - 4.
    assign j_target = ADDR_W'({4'(32'(pc_q) >> 28), ir_q[25:0], 2'b00});
    assign j_halt   = HALT_ON_J && is_j && (j_target == pc_q - ADDR_W'(4));

    assign alu_a = a_q;
    assign alu_b = is_rtype ? b_q : imm_sext;

    // Shared ALU: R-type selects by funct, everything else adds the sign-extended immediate
    always_comb begin
        alu_res = alu_a + alu_b;
        if (is_rtype) begin
            case (funct)
                FN_SUB:  alu_res = alu_a - alu_b;
                FN_AND:  alu_res = alu_a & alu_b;
                FN_OR:   alu_res = alu_a | alu_b;
                FN_SLT:  alu_res = {31'b0, alu_a < alu_b};
                default: alu_res = alu_a + alu_b;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    // FSM next-state: memory states wait for mem_ready, EXEC branches on the opcode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if ((is_rtype && rfn_ok) || is_addi) state_d = S_WB;
                else if (is_lw || is_sw)             state_d = S_MEM;
                else if (j_halt)                     state_d = S_HALT;
                else if (illegal && TRAP_EN)         state_d = S_HALT;
                else                                 state_d = S_FETCH;
            end
            S_MEM:    if (mem_ready) state_d = is_sw ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    // FSM outputs; gated by rst so a mid-transfer reset drops the request at once
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                end
                S_EXEC:  retire = is_beq || (is_j && !j_halt) || (illegal && !TRAP_EN);
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = is_sw;
                    mem_addr  = {aluout_q[ADDR_W-1:2], 2'b00};
                    mem_wdata = b_q;
                    retire    = is_sw && mem_ready;
                end
                S_WB:    retire = 1'b1;
                default: ;
            endcase
        end
    end

    assign halted = (state_q == S_HALT);
    assign dbg_pc = pc_q;

    // Datapath next-state: each FSM state loads only the registers it owns
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        case (state_q)
            S_FETCH: if (mem_ready) begin
                ir_d = mem_rdata;
                pc_d = pc_q + ADDR_W'(4);
            end
            S_DECODE: begin
                a_d      = regs_q[ir_q[25:21]];
                b_d      = regs_q[ir_q[20:16]];
                aluout_d = 32'(pc_q) + 32'(imm_sext <<< 2);
            end
            S_EXEC: begin
                if ((is_rtype && rfn_ok) || is_addi || is_lw || is_sw) aluout_d = alu_res;
                if (is_beq && (a_q == b_q)) pc_d = aluout_q[ADDR_W-1:0];
                if (is_j) pc_d = j_target;
            end
            S_MEM: if (mem_ready && !is_sw) mdr_d = mem_rdata;
            default: ;
        endcase
    end

    assign rf_we    = (state_q == S_WB);
    assign rf_waddr = is_rtype ? ir_q[15:11] : ir_q[20:16];
    assign rf_wdata = is_lw ? mdr_q : aluout_q;

    // Datapath and register file; $0 is never written so it always reads 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC[ADDR_W-1:0];
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            if (rf_we && (rf_waddr != 5'd0)) regs_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: runs small hand-assembled programs against a
// word memory model with a programmable data-phase stall, and checks results that the
// programs store back to memory, retire timing, handshake stability and reset behaviour.
module tb_mips_multicycle_core;
    logic        clk;
    logic        rst;
    logic        mem_req, mem_we, mem_ready, halted, retire;
    logic [13:0] mem_addr, dbg_pc;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    // memory model: program image written by the stimulus, stores kept separately
    logic [31:0] img     [256];
    logic [31:0] st_data [256];
    bit          st_vld  [256];
    bit          st_clr;
    bit          ovr_en, ovr_val;
    int          dstall, wcnt;
    logic        data_ph;

    // retire monitor
    bit          mon_clr;
    int          cyc, rcnt, snap_cnt;
    bit          snap_ok;
    logic [13:0] snap_addr;
    int          rc [64];

    mips_multicycle_core #(.ADDR_W(14), .RESET_PC(32'h0), .HALT_ON_J(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .retire(retire), .dbg_pc(dbg_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_ph   = (mem_addr >= 14'h100);
    assign mem_ready = ovr_en ? ovr_val : !(mem_req && data_ph && (wcnt < dstall));
    assign mem_rdata = st_vld[mem_addr[9:2]] ? st_data[mem_addr[9:2]] : img[mem_addr[9:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (mem_req && data_ph) wcnt <= mem_ready ? 0 : wcnt + 1;
    end

    always @(posedge clk) begin
        if (st_clr) begin
            for (int i = 0; i < 256; i++) st_vld[i] <= 1'b0;
        end else if (rst && mem_req && mem_we && mem_ready) begin
            st_vld[mem_addr[9:2]]  <= 1'b1;
            st_data[mem_addr[9:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            cyc = 0; rcnt = 0; snap_ok = 0; snap_cnt = 0;
        end else begin
            cyc++;
            if (retire && rcnt < 64) begin
                rc[rcnt] = cyc;
                rcnt++;
            end
            if (mem_req && !mem_we && mem_addr == snap_addr && !snap_ok) begin
                snap_ok  = 1;
                snap_cnt = rcnt;
            end
        end
    end

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(int tgt);
        return {6'h02, 26'(tgt >> 2)};
    endfunction
    function automatic logic [31:0] rdw(int a);
        return st_vld[a >> 2] ? st_data[a >> 2] : img[a >> 2];
    endfunction

    task automatic put(input int a, input logic [31:0] w);
        img[a >> 2] = w;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = (i >= 64) ? 32'hDEADBEEF : 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_halt(input int bound, input string tag);
        int n = 0;
        while (halted !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, halted}, 32'h1);
    endtask

    task automatic wait_req(input logic we, input logic [13:0] addr, input string tag);
        int n = 0;
        while (!(mem_req === 1'b1 && mem_we === we && mem_addr === addr) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, mem_req}, 32'h1);
    endtask

    // put the core in reset and clear the store log and the retire monitor
    task automatic enter_reset();
        rst = 1'b0;
        st_clr = 1'b1;
        mon_clr = 1'b1;
        tick();
        tick();
        st_clr = 1'b0;
        mon_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ovr_en = 1'b1; ovr_val = 1'b0; dstall = 0;
        st_clr = 1'b1; mon_clr = 1'b1; snap_addr = 14'h90;

        // ALU, memory and control program
        clear_img();
        put(32'h00, enc_i(8, 0, 1, 5));
        put(32'h04, enc_i(8, 0, 2, -3));
        put(32'h08, enc_r(1, 2, 3, 'h20));
        put(32'h0C, enc_r(1, 2, 4, 'h22));
        put(32'h10, enc_r(1, 2, 5, 'h24));
        put(32'h14, enc_r(1, 2, 6, 'h25));
        put(32'h18, enc_r(1, 2, 7, 'h2A));
        put(32'h1C, enc_i(8, 0, 0, 7));
        put(32'h20, enc_i('h2B, 0, 3, 'h200));
        put(32'h24, enc_i('h2B, 0, 4, 'h204));
        put(32'h28, enc_i('h2B, 0, 5, 'h208));
        put(32'h2C, enc_i('h2B, 0, 6, 'h20C));
        put(32'h30, enc_i('h2B, 0, 7, 'h210));
        put(32'h34, enc_i('h2B, 0, 0, 'h214));
        put(32'h38, enc_i('h2B, 0, 1, 'h13));
        put(32'h3C, enc_i('h23, 0, 8, 'h10));
        put(32'h40, enc_i('h2B, 0, 8, 'h218));
        put(32'h44, enc_i(8, 0, 9, 3));
        put(32'h48, enc_i(4, 9, 0, 3));
        put(32'h4C, enc_i(8, 9, 9, -1));
        put(32'h50, enc_i(8, 10, 10, 1));
        put(32'h54, enc_i(4, 0, 0, -4));
        put(32'h58, enc_i('h2B, 0, 10, 'h21C));
        put(32'h5C, enc_j('h80));
        put(32'h60, enc_i(8, 0, 12, 'h66));
        put(32'h80, enc_i('h2B, 0, 12, 'h220));
        put(32'h84, 32'hFC000000);
        put(32'h88, enc_i(8, 0, 13, 'h77));
        put(32'h8C, enc_i('h2B, 0, 13, 'h224));
        put(32'h90, enc_j('h90));

        // reset held with mem_ready toggling
        for (int i = 0; i < 4; i++) begin
            tick();
            ovr_val = ~ovr_val;
            chk($sformatf("rst_req%0d", i), {31'b0, mem_req}, 32'h0);
            chk($sformatf("rst_pc%0d", i), {18'b0, dbg_pc}, 32'h0);
            chk($sformatf("rst_halt%0d", i), {31'b0, halted}, 32'h0);
        end
        chk("rst_addr", {18'b0, mem_addr}, 32'h0);
        chk("rst_retire", {31'b0, retire}, 32'h0);
        st_clr = 1'b0; mon_clr = 1'b0; ovr_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel_req", {31'b0, mem_req}, 32'h1);
        chk("rel_addr", {18'b0, mem_addr}, 32'h0);
        chk("rel_we", {31'b0, mem_we}, 32'h0);

        wait_halt(2000, "progA_halt");
        chk("add", rdw('h200), 32'h2);
        chk("sub", rdw('h204), 32'h8);
        chk("and", rdw('h208), 32'h5);
        chk("or", rdw('h20C), 32'hFFFFFFFD);
        chk("slt", rdw('h210), 32'h0);
        chk("r0_zero", rdw('h214), 32'h0);
        chk("sw_low_bits", rdw('h10), 32'h5);
        chk("lw_value", rdw('h218), 32'h5);
        chk("beq_loop", rdw('h21C), 32'h3);
        chk("j_target", rdw('h220), 32'h0);
        chk("cyc_addi", rc[1] - rc[0], 4);
        chk("cyc_add", rc[2] - rc[1], 4);
        chk("cyc_sw", rc[8] - rc[7], 4);
        chk("cyc_lw", rc[15] - rc[14], 5);
        chk("cyc_beq_nt", rc[18] - rc[17], 3);
        chk("cyc_beq_t", rc[21] - rc[20], 3);
        chk("cyc_j", rc[32] - rc[31], 3);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        chk("trap_retires", rcnt, 34);
        chk("trap_pc", {18'b0, dbg_pc}, 32'h88);
        chk("trap_no_exec", rdw('h224), 32'hDEADBEEF);
`else
        chk("illegal_nop", rdw('h224), 32'h77);
        chk("cyc_illegal", rc[34] - rc[33], 3);
        chk("retires_at_jself", {31'b0, snap_ok}, 32'h1);
        chk("retire_count", snap_cnt, 37);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("halt_req%0d", i), {31'b0, mem_req}, 32'h0);
            chk($sformatf("halt_flag%0d", i), {31'b0, halted}, 32'h1);
            chk($sformatf("halt_retire%0d", i), {31'b0, retire}, 32'h0);
        end

        // stalled data transfers
        enter_reset();
        clear_img();
        put(32'h00, enc_i(8, 0, 1, 'h55));
        put(32'h04, enc_i('h2B, 0, 1, 'h100));
        put(32'h08, enc_i('h23, 0, 8, 'h180));
        put(32'h0C, enc_i('h2B, 0, 8, 'h104));
        put(32'h10, enc_j('h10));
        put(32'h180, 32'h12345678);
        dstall = 3;
        rst = 1'b1;
        wait_req(1'b1, 14'h100, "sw_req_seen");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sw_stall_req%0d", i), {31'b0, mem_req}, 32'h1);
            chk($sformatf("sw_stall_we%0d", i), {31'b0, mem_we}, 32'h1);
            chk($sformatf("sw_stall_addr%0d", i), {18'b0, mem_addr}, 32'h100);
            chk($sformatf("sw_stall_wdata%0d", i), mem_wdata, 32'h55);
        end
        wait_req(1'b0, 14'h180, "lw_req_seen");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("lw_stall_req%0d", i), {31'b0, mem_req}, 32'h1);
            chk($sformatf("lw_stall_addr%0d", i), {18'b0, mem_addr}, 32'h180);
        end
        wait_halt(500, "progB_halt");
        chk("stall_sw_data", rdw('h100), 32'h55);
        chk("stall_lw_data", rdw('h104), 32'h12345678);
        chk("cyc_sw_stall", rc[1] - rc[0], 7);
        chk("cyc_lw_stall", rc[2] - rc[1], 8);

        // reset in the middle of a load
        enter_reset();
        clear_img();
        put(32'h00, enc_i('h23, 0, 8, 'h100));
        put(32'h04, enc_j('h04));
        dstall = 100;
        rst = 1'b1;
        wait_req(1'b0, 14'h100, "mid_lw_seen");
        tick();
        tick();
        chk("mid_lw_still_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, mem_req}, 32'h0);
        chk("mid_rst_addr", {18'b0, mem_addr}, 32'h0);
        chk("mid_rst_pc", {18'b0, dbg_pc}, 32'h0);
        put(32'h00, enc_i('h2B, 0, 8, 'h108));
        dstall = 0;
        enter_reset();
        rst = 1'b1;
        #1;
        chk("mid_rel_req", {31'b0, mem_req}, 32'h1);
        chk("mid_rel_addr", {18'b0, mem_addr}, 32'h0);
        wait_halt(500, "progC_halt");
        chk("r8_unwritten", rdw('h108), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
